// File: rtl/regfile_dump_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_dump_uart_pkg
//  Description : Shared processor-debug definitions: frame FSM encoding,
//                UART bit-slot encoding, frame constants, byte helper.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_dump_uart_pkg;

    // Width of one architectural register on the tap bus
    localparam int REG_W = 32;

    // Frame FSM encoding
    localparam int                 STATE_W = 4;
    localparam logic [STATE_W-1:0] ST_IDLE = 4'd0;
    localparam logic [STATE_W-1:0] ST_SYNC = 4'd1;
    localparam logic [STATE_W-1:0] ST_IDX  = 4'd2;
    localparam logic [STATE_W-1:0] ST_D3   = 4'd3;
    localparam logic [STATE_W-1:0] ST_D2   = 4'd4;
    localparam logic [STATE_W-1:0] ST_D1   = 4'd5;
    localparam logic [STATE_W-1:0] ST_D0   = 4'd6;
    localparam logic [STATE_W-1:0] ST_CSUM = 4'd7;
    localparam logic [STATE_W-1:0] ST_DONE = 4'd8;

    // Leading marker byte of every dump frame
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // UART bit-slot numbering: 0 = start, 1..8 = data, 9 = stop
    localparam logic [3:0] BIT_START = 4'd0;
    localparam logic [3:0] BIT_STOP  = 4'd9;

    // Byte sel of a 32-bit word, sel 3 = most significant byte
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd3:    b = word[31:24];
            2'd2:    b = word[23:16];
            2'd1:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_dump_uart_uart_byte_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_tx
//  Description : 8N1 byte serialiser. The core counters walk the bit slots;
//                the line itself is a register one cycle behind the core, so
//                an accepted byte's start bit appears the cycle after the
//                handshake and back-to-back bytes leave no idle gap.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_byte_tx
    import regfile_dump_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    // The core spends one cycle less in the stop slot: its idle cycle (which
    // is also the next byte's handshake cycle) supplies the final stop cycle.
    localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(CLKS_PER_BIT - 2);

    logic              active_q, active_d;
    logic [BAUD_W-1:0] baud_q,   baud_d;
    logic [3:0]        bit_q,    bit_d;
    logic [7:0]        shift_q,  shift_d;
    logic              tx_q;
    logic              w_line;

    assign tx_ready = ~active_q;
    assign uart_tx  = tx_q;

    // Line level the core wants for its current bit slot
    always_comb begin
        w_line = 1'b1;
        if (active_q) begin
            if (bit_q == BIT_START) begin
                w_line = 1'b0;
            end else if (bit_q == BIT_STOP) begin
                w_line = 1'b1;
            end else begin
                w_line = shift_q[0];
            end
        end
    end

    // Baud / bit counter and shift register advance
    always_comb begin
        active_d = active_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        if (!active_q) begin
            if (tx_valid) begin
                active_d = 1'b1;
                baud_d   = '0;
                bit_d    = BIT_START;
                shift_d  = tx_data;
            end
        end else if (bit_q == BIT_STOP && baud_q == STOP_LAST) begin
            active_d = 1'b0;
            baud_d   = '0;
            bit_d    = BIT_START;
        end else if (baud_q == BAUD_LAST) begin
            baud_d = '0;
            bit_d  = bit_q + 4'd1;
            if (bit_q != BIT_START) begin
                shift_d = {1'b0, shift_q[7:1]};
            end
        end else begin
            baud_d = baud_q + BAUD_W'(1);
        end
    end

    // Serialiser state and registered line output
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            baud_q   <= '0;
            bit_q    <= BIT_START;
            shift_q  <= 8'h00;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= w_line;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_dump_uart.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_dump_uart
//  Description : On start, snapshots the register taps and streams
//                SYNC, {index, 4 data bytes MSB first} per register, and an
//                XOR checksum as an 8N1 UART frame.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_dump_uart
    import regfile_dump_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_REGS     = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [REG_W*NUM_REGS-1:0] reg_bus,
    output logic                      uart_tx,
    output logic                      busy,
    output logic                      done
);

    localparam int               IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    logic [STATE_W-1:0]        state_q, state_d;
    logic [REG_W*NUM_REGS-1:0] snap_q, snap_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [7:0]                csum_q, csum_d;
    logic                      csum_sent_q, csum_sent_d;
    logic                      tx_ready_q;

    logic [REG_W-1:0]          w_word;
    logic [7:0]                w_tx_data;
    logic                      w_tx_valid;
    logic                      w_tx_ready;
    logic                      w_hs;

    assign w_hs = w_tx_valid & w_tx_ready;

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clock    (clock),
        .reset    (reset),
        .tx_data  (w_tx_data),
        .tx_valid (w_tx_valid),
        .tx_ready (w_tx_ready),
        .uart_tx  (uart_tx)
    );

    // Select the snapshot word of the register currently being sent
    always_comb begin
        w_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                w_word = snap_q[i*REG_W +: REG_W];
            end
        end
    end

    // Frame state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame next-state: each byte state advances on its handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_SYNC;
            ST_SYNC: if (w_hs)  state_d = ST_IDX;
            ST_IDX:  if (w_hs)  state_d = ST_D3;
            ST_D3:   if (w_hs)  state_d = ST_D2;
            ST_D2:   if (w_hs)  state_d = ST_D1;
            ST_D1:   if (w_hs)  state_d = ST_D0;
            ST_D0:   if (w_hs)  state_d = (idx_q == LAST_IDX) ? ST_CSUM : ST_IDX;
            // The line lags the serialiser core by one cycle, so the last stop
            // bit ends one cycle after the core reports idle again.
            ST_CSUM: if (csum_sent_q && w_tx_ready && tx_ready_q) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame outputs: byte presented to the serialiser plus busy/done
    always_comb begin
        w_tx_valid = 1'b0;
        w_tx_data  = 8'h00;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: busy = 1'b0;
            ST_SYNC: begin
                w_tx_valid = 1'b1;
                w_tx_data  = SYNC_BYTE;
            end
            ST_IDX: begin
                w_tx_valid = 1'b1;
                w_tx_data  = 8'(idx_q);
            end
            ST_D3: begin
                w_tx_valid = 1'b1;
                w_tx_data  = word_byte(w_word, 2'd3);
            end
            ST_D2: begin
                w_tx_valid = 1'b1;
                w_tx_data  = word_byte(w_word, 2'd2);
            end
            ST_D1: begin
                w_tx_valid = 1'b1;
                w_tx_data  = word_byte(w_word, 2'd1);
            end
            ST_D0: begin
                w_tx_valid = 1'b1;
                w_tx_data  = word_byte(w_word, 2'd0);
            end
            ST_CSUM: begin
                w_tx_valid = ~csum_sent_q;
                w_tx_data  = csum_q;
            end
            ST_DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // Snapshot, register index and checksum bookkeeping
    always_comb begin
        snap_d      = snap_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        csum_sent_d = csum_sent_q;
        if (state_q == ST_IDLE && start) begin
            snap_d      = reg_bus;
            idx_d       = '0;
            csum_d      = 8'h00;
            csum_sent_d = 1'b0;
        end else if (w_hs) begin
            case (state_q)
                ST_IDX, ST_D3, ST_D2, ST_D1: csum_d = csum_q ^ w_tx_data;
                ST_D0: begin
                    csum_d = csum_q ^ w_tx_data;
                    idx_d  = idx_q + IDX_W'(1);
                end
                ST_CSUM: csum_sent_d = 1'b1;
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snap_q      <= '0;
            idx_q       <= '0;
            csum_q      <= 8'h00;
            csum_sent_q <= 1'b0;
            tx_ready_q  <= 1'b0;
        end else begin
            snap_q      <= snap_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            csum_sent_q <= csum_sent_d;
            tx_ready_q  <= w_tx_ready;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_uart.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_dump_uart
//  Description : Directed self-checking bench for regfile_dump_uart
//                (CLKS_PER_BIT=4, NUM_REGS=32).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_dump_uart;

    localparam int CPB         = 4;
    localparam int NR          = 32;
    localparam int FRAME_BYTES = 5*NR + 2;               // 162
    localparam int DONE_LAT    = FRAME_BYTES*10*CPB + 2; // 6482

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [32*NR-1:0] reg_bus;
    logic            uart_tx;
    logic            busy;
    logic            done;

    logic [31:0]     model_regs [NR];
    logic [7:0]      rx_q [$];
    int              checks   = 0;
    int              errors   = 0;
    int              done_cnt = 0;
    int              rx_cnt   = 0;
    logic            rx_on    = 1'b0;
    logic [7:0]      rx_byte  = 8'h00;

    always #5 clk = ~clk;

    regfile_dump_uart #(
        .CLKS_PER_BIT (CPB),
        .NUM_REGS     (NR)
    ) dut (
        .clock   (clk),
        .reset   (reset),
        .start   (start),
        .reg_bus (reg_bus),
        .uart_tx (uart_tx),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle-exact UART receiver sampling mid-bit; also counts done pulses
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (uart_tx === 1'b0) begin
                rx_on  = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == CPB/2) begin
                check("rx_start_bit", uart_tx, 1'b0);
            end
            if ((rx_cnt % CPB) == CPB/2 && rx_cnt >= CPB && rx_cnt < 9*CPB) begin
                rx_byte = {uart_tx, rx_byte[7:1]};
            end
            if (rx_cnt == 9*CPB + CPB/2) begin
                check("rx_stop_bit", uart_tx, 1'b1);
                rx_q.push_back(rx_byte);
                rx_on = 1'b0;
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    function automatic logic [7:0] rx_at(input int j);
        if (j < rx_q.size()) return rx_q[j];
        return 8'hxx;
    endfunction

    task automatic set_reg(input int i, input logic [31:0] v);
        reg_bus[32*i +: 32] = v;
        model_regs[i]       = v;
    endtask

    task automatic clear_regs();
        reg_bus = '0;
        for (int i = 0; i < NR; i++) model_regs[i] = 32'h0;
    endtask

    // One-cycle start pulse; returns on the falling edge right after the sampling edge
    task automatic pulse_start(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check(tag, busy, 1'b1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int k0, output int kd, output logic pb);
        kd = k0;
        pb = busy;
        while (done !== 1'b1 && kd < DONE_LAT + 200) begin
            pb = busy;
            @(negedge clk);
            kd++;
        end
    endtask

    task automatic wait_bytes(input int n);
        int guard = 0;
        while (rx_q.size() < n && guard < 8000) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("reached_byte%0d", n), (rx_q.size() >= n), 1'b1);
    endtask

    task automatic check_frame(input string tag);
        logic [7:0] exp_b [$];
        logic [7:0] cs;
        exp_b.push_back(8'hA5);
        for (int i = 0; i < NR; i++) begin
            exp_b.push_back(8'(i));
            exp_b.push_back(model_regs[i][31:24]);
            exp_b.push_back(model_regs[i][23:16]);
            exp_b.push_back(model_regs[i][15:8]);
            exp_b.push_back(model_regs[i][7:0]);
        end
        cs = 8'h00;
        for (int j = 1; j < exp_b.size(); j++) cs = cs ^ exp_b[j];
        exp_b.push_back(cs);
        check({tag, "_len"}, rx_q.size(), FRAME_BYTES);
        for (int j = 0; j < FRAME_BYTES; j++) begin
            check($sformatf("%s_byte%0d", tag, j), rx_at(j), exp_b[j]);
        end
    endtask

    initial begin
        int         kd;
        logic       pb;
        logic       exp_bit;
        logic [9:0] sync_line;

        // ---- 1: reset held with start high, then release ----
        reset = 1'b0;
        start = 1'b1;
        clear_regs();
        repeat (6) begin
            @(negedge clk);
            check("rst_uart_tx", uart_tx, 1'b1);
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
        end
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("idle_uart_tx", uart_tx, 1'b1);
            check("idle_busy", busy, 1'b0);
            check("idle_done", done, 1'b0);
        end

        // ---- 2 + 3: SYNC bit timing and full dump with reg3 = DEADBEEF ----
        set_reg(3, 32'hDEADBEEF);
        rx_q.delete();
        done_cnt  = 0;
        sync_line = 10'b1101001010;  // stop,A5 msb..lsb,start
        pulse_start("busy_rise");
        for (int k = 0; k < 2 + 10*CPB; k++) begin
            if (k > 0) @(negedge clk);
            exp_bit = (k < 2) ? 1'b1 : sync_line[(k-2)/CPB];
            check($sformatf("sync_line_k%0d", k), uart_tx, exp_bit);
        end
        wait_done(1 + 10*CPB, kd, pb);
        check("done_latency", kd, DONE_LAT);
        check("busy_before_done", pb, 1'b1);
        check("busy_at_done", busy, 1'b0);
        @(negedge clk);
        check("done_width", done, 1'b0);
        repeat (20) @(negedge clk);
        check("done_pulses", done_cnt, 1);
        check_frame("dump");
        check("reg3_index", rx_at(16), 8'h03);
        check("reg3_msb", rx_at(17), 8'hDE);
        check("reg3_lsb", rx_at(20), 8'hEF);
        check("reg31_index", rx_at(156), 8'h1F);
        check("csum_value", rx_at(161), 8'h22);

        // ---- 4 + 5: snapshot integrity and starts while busy ----
        clear_regs();
        set_reg(3, 32'hDEADBEEF);
        set_reg(31, 32'h80000001);
        rx_q.delete();
        done_cnt = 0;
        pulse_start("busy_rise2");
        reg_bus[32*3 +: 32]  = 32'h00000000;
        reg_bus[32*31 +: 32] = 32'hFFFFFFFF;
        wait_bytes(10);
        pulse_start("busy_held_b10");
        wait_bytes(161);
        pulse_start("busy_held_b161");
        wait_done(0, kd, pb);
        check("done_seen2", done, 1'b1);
        repeat (100) @(negedge clk);
        check("done_pulses2", done_cnt, 1);
        check("idle_after2", busy, 1'b0);
        check_frame("snap");

        // ---- 6: asynchronous reset mid-frame, then a clean frame ----
        clear_regs();
        set_reg(0, 32'h01234567);
        set_reg(3, 32'hDEADBEEF);
        set_reg(31, 32'hCAFEF00D);
        rx_q.delete();
        done_cnt = 0;
        pulse_start("busy_rise3");
        wait_bytes(50);
        repeat (10) @(negedge clk);
        check("pre_reset_line", uart_tx, 1'b0);
        check("pre_reset_busy", busy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_tx", uart_tx, 1'b1);
        check("rst_async_busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rx_q.delete();
        done_cnt = 0;
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_idle", busy, 1'b0);
        set_reg(5, 32'h5A5A0F0F);
        pulse_start("busy_rise4");
        wait_done(0, kd, pb);
        check("done_latency4", kd, DONE_LAT);
        repeat (20) @(negedge clk);
        check("done_pulses4", done_cnt, 1);
        check_frame("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
